// File: rtl/write_ptr_full.sv
// write_ptr_full: write-domain pointer and full flag of an async FIFO; ALMOST_FULL_EN adds almost_full
module write_ptr_full #(
  parameter int Address = 2
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               w_en,
  input  logic [Address:0]   r_gptr,
  output logic [Address-1:0] w_addr,
  output logic [Address:0]   w_gptr,
  output logic               full,
  output logic               w_accept
`ifdef ALMOST_FULL_EN
  ,
  output logic               almost_full
`endif
);
  logic [Address:0] rq1, rq2, wbin, wbin_next, gray_next;
  logic             full_next;
  assign w_accept  = w_en & ~full;
  assign wbin_next = wbin + (Address+1)'(w_accept);
  assign gray_next = (wbin_next >> 1) ^ wbin_next;
  assign full_next = gray_next == {~rq2[Address:Address-1], rq2[Address-2:0]};
  assign w_addr    = wbin[Address-1:0];
  // two-flop synchronizer bringing the read Gray pointer into the write domain
  always_ff @(posedge w_clk or negedge w_rst)
    if (!w_rst) {rq2, rq1} <= '0;
    else        {rq2, rq1} <= {rq1, r_gptr};
  // binary/Gray write pointer and full flag, all updated on the same edge
  always_ff @(posedge w_clk or negedge w_rst)
    if (!w_rst) begin
      wbin   <= '0;
      w_gptr <= '0;
      full   <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      w_gptr <= gray_next;
      full   <= full_next;
    end
`ifdef ALMOST_FULL_EN
  localparam logic [Address:0] AfLevel = (Address+1)'((1 << Address) - 1);
  logic [Address:0] rbin;
  genvar g;
  for (g = 0; g <= Address; g++) begin : g_g2b
    assign rbin[g] = ^rq2[Address:g];
  end
  // almost_full: at most one free entry left after this edge's write
  always_ff @(posedge w_clk or negedge w_rst)
    if (!w_rst) almost_full <= 1'b0;
    else        almost_full <= (wbin_next - rbin) >= AfLevel;
`endif
endmodule

// File: tb/tb_write_ptr_full.sv
// tb_write_ptr_full: scoreboard bench for write_ptr_full (Address=2); covers ALMOST_FULL_EN when defined
module tb_write_ptr_full;
  logic       w_clk = 1'b0, w_rst = 1'b1, w_en = 1'b0;
  logic [2:0] r_gptr = 3'b000;
  logic [1:0] w_addr;
  logic [2:0] w_gptr;
  logic       full, w_accept;
`ifdef ALMOST_FULL_EN
  logic       almost_full;
`endif
  int total = 0, bad = 0;
  typedef struct {
    string      name;
    logic [1:0] addr;
    logic [2:0] gptr;
    logic       full;
    logic       af;
  } exp_t;
  exp_t sb[$];
  write_ptr_full #(.Address(2)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .r_gptr(r_gptr),
    .w_addr(w_addr), .w_gptr(w_gptr), .full(full), .w_accept(w_accept)
`ifdef ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );
  always #5 w_clk = ~w_clk;
  function automatic logic [2:0] gray(input int k);
    logic [2:0] b;
    b = 3'(k);
    return (b >> 1) ^ b;
  endfunction
  task automatic test_reset;
    exp_t e;
    #1 w_rst = 1'b0;
    #1;
    sb.push_back('{"reset_async", 2'd0, 3'b000, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
      bad++;
      $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
    end
    for (int i = 0; i < 4; i++) begin
      w_en = ~w_en;
      sb.push_back('{$sformatf("reset_hold%0d", i), 2'd0, 3'b000, 1'b0, 1'b0});
      @(posedge w_clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
      end
    end
    w_en = 1'b0;
    w_rst = 1'b1;
  endtask
  task automatic test_fill;
    logic [1:0] addrs [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] gptrs [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    exp_t e;
    r_gptr = 3'b000;
    w_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (w_accept !== 1'b1) begin
        bad++;
        $display("FAIL fill_accept%0d: got w_accept=%b want 1", i, w_accept);
      end
      sb.push_back('{$sformatf("fill%0d", i), addrs[i], gptrs[i], i == 3, 1'b0});
      @(posedge w_clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
      end
    end
  endtask
  task automatic test_overflow;
    exp_t e;
    w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (w_accept !== 1'b0) begin
        bad++;
        $display("FAIL overflow_accept%0d: got w_accept=%b want 0", i, w_accept);
      end
      sb.push_back('{$sformatf("overflow%0d", i), 2'd0, 3'b110, 1'b1, 1'b0});
      @(posedge w_clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
      end
    end
  endtask
  task automatic test_drain;
    exp_t e;
    w_en = 1'b0;
    r_gptr = 3'b001;
    for (int i = 0; i < 3; i++) sb.push_back('{$sformatf("drain%0d", i), 2'd0, 3'b110, i < 2, 1'b0});
    sb.push_back('{"drain_refill", 2'd1, 3'b111, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        w_en = 1'b1;
        #1;
        total++;
        if (w_accept !== 1'b1) begin
          bad++;
          $display("FAIL drain_accept: got w_accept=%b want 1", w_accept);
        end
      end
      @(posedge w_clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
      end
    end
    w_en = 1'b0;
  endtask
  task automatic test_wrap;
    exp_t e;
    w_rst = 1'b0;
    r_gptr = 3'b000;
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    w_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sb.push_back('{$sformatf("wrap%0d", k), 2'(k), gray(k), 1'b0, 1'b0});
      @(posedge w_clk);
      #1;
      r_gptr = w_gptr;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
      end
    end
    w_en = 1'b0;
  endtask
  task automatic test_reset_mid;
    exp_t e;
    w_rst = 1'b0;
    r_gptr = 3'b000;
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    w_en = 1'b1;
    repeat (2) @(posedge w_clk);
    #3 w_rst = 1'b0;
    #1;
    sb.push_back('{"midreset_async", 2'd0, 3'b000, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
      bad++;
      $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
    end
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    sb.push_back('{"midreset_first_write", 2'd1, 3'b001, 1'b0, 1'b0});
    @(posedge w_clk);
    #1;
    e = sb.pop_front();
    total++;
    if ({w_addr, w_gptr, full} !== {e.addr, e.gptr, e.full}) begin
      bad++;
      $display("FAIL %s: got addr=%0d gptr=%b full=%b want addr=%0d gptr=%b full=%b", e.name, w_addr, w_gptr, full, e.addr, e.gptr, e.full);
    end
    w_en = 1'b0;
  endtask
`ifdef ALMOST_FULL_EN
  task automatic test_almost_full;
    exp_t e;
    w_rst = 1'b0;
    r_gptr = 3'b000;
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    w_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{$sformatf("af%0d", k), 2'(k), gray(k), 1'b0, k == 3});
      @(posedge w_clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({w_addr, w_gptr, full, almost_full} !== {e.addr, e.gptr, e.full, e.af}) begin
        bad++;
        $display("FAIL %s: got addr=%0d gptr=%b full=%b af=%b want addr=%0d gptr=%b full=%b af=%b", e.name, w_addr, w_gptr, full, almost_full, e.addr, e.gptr, e.full, e.af);
      end
    end
    w_en = 1'b0;
    #2 w_rst = 1'b0;
    #1;
    sb.push_back('{"af_reset", 2'd0, 3'b000, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({w_addr, w_gptr, full, almost_full} !== {e.addr, e.gptr, e.full, e.af}) begin
      bad++;
      $display("FAIL %s: got addr=%0d gptr=%b full=%b af=%b want addr=%0d gptr=%b full=%b af=%b", e.name, w_addr, w_gptr, full, almost_full, e.addr, e.gptr, e.full, e.af);
    end
    @(posedge w_clk);
    #1 w_rst = 1'b1;
  endtask
`endif
  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_drain;
    test_wrap;
    test_reset_mid;
`ifdef ALMOST_FULL_EN
    test_almost_full;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
